// File: rtl/nn_acc_requant.sv
// -----------------------------------------------------------------------------
// nn_acc_requant
//
// Sums cfg_len unsigned products from the multiplier array into a saturating
// accumulator. It then adds a signed bias, rounds half up and arithmetic
// right-shifts the sum. The result is clamped to an unsigned OUT_WIDTH
// activation. Negative values become 0, which acts as an implicit ReLU.
//
// Ports
//   ap_clk, ap_rst_n      clock (rising edge), asynchronous active-low reset
//   cfg_len/shift/bias    job configuration, latched on the first accepted product
//   in_valid/ready/data   product stream; one product per cycle while accumulating
//   out_valid/ready/data  clamped result; held stable until accepted
//   busy                  high whenever the block is not idle
// -----------------------------------------------------------------------------
module nn_acc_requant #(
    parameter int PROD_WIDTH  = 36,
    parameter int ACC_WIDTH   = 48,
    parameter int OUT_WIDTH   = 18,
    parameter int CNT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [CNT_WIDTH-1:0]   cfg_len,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic [ACC_WIDTH-1:0]   cfg_bias,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PROD_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   busy
);

    // The signed sum needs two extra bits: one for the sign, and one for the
    // headroom of an unsigned accumulator plus a signed bias.
    localparam int SW = ACC_WIDTH + 2;
    // The rounding addend needs one more bit so the add cannot overflow.
    localparam int RW = SW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_FIN,
        S_OUT
    } state_e;

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic [ACC_WIDTH-1:0]   bias_q, bias_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;

    logic                   accept;
    logic [ACC_WIDTH:0]     acc_sum;
    logic [ACC_WIDTH-1:0]   acc_sat;
    logic [CNT_WIDTH-1:0]   cnt_inc;

    logic signed [SW-1:0]   sum_s;
    logic        [RW-1:0]   round_add;
    logic signed [RW-1:0]   rnd_s;
    logic signed [RW-1:0]   shr_s;
    logic [OUT_WIDTH-1:0]   req_result;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACC);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;
    assign accept    = in_valid && in_ready;

    // Accumulate with one carry bit. If the carry is set, the accumulator pins at all-ones.
    assign acc_sum = {1'b0, acc_q} + (ACC_WIDTH + 1)'(in_data);
    assign acc_sat = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    // Requantisation, which is only consumed in FIN.
    assign sum_s = $signed({2'b00, acc_q}) + $signed({{2{bias_q[ACC_WIDTH-1]}}, bias_q});

    // Skip the rounding addend for shifts beyond the sum width. In that case
    // the shifted value is 0 or -1 and clamps to 0 regardless.
    assign round_add = (shift_q != '0 && int'(shift_q) <= SW)
                     ? (RW'(1) << (shift_q - SHIFT_WIDTH'(1))) : '0;
    assign rnd_s     = $signed({sum_s[SW-1], sum_s}) + $signed(round_add);
    assign shr_s     = rnd_s >>> shift_q;

    always_comb begin
        if (shr_s[RW-1]) begin
            req_result = '0;
        end else if (|shr_s[RW-2:OUT_WIDTH]) begin
            req_result = '1;
        end else begin
            req_result = shr_s[OUT_WIDTH-1:0];
        end
    end

    // NOTE: every next-state signal gets a default that holds the current
    // value first. A branch that forgets an assignment then stays
    // combinational and does not infer a latch.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        shift_d    = shift_q;
        bias_d     = bias_q;
        out_data_d = out_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    len_d   = cfg_len;
                    shift_d = cfg_shift;
                    bias_d  = cfg_bias;
                    acc_d   = ACC_WIDTH'(in_data);
                    cnt_d   = CNT_WIDTH'(1);
                    // A length of 0 or 1 means this product is the whole job.
                    state_d = (cfg_len <= CNT_WIDTH'(1)) ? S_FIN : S_ACC;
                end
            end
            S_ACC: begin
                if (accept) begin
                    acc_d = acc_sat;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                out_data_d = req_result;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments. All flops then
    // sample their inputs in the same edge, whatever order they are written in.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            bias_q     <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            bias_q     <= bias_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_nn_acc_requant.sv
// -----------------------------------------------------------------------------
// tb_nn_acc_requant
//
// Self-checking bench for nn_acc_requant. Each job pushes its expected result,
// computed with plain integer arithmetic, onto a scoreboard queue. The queue
// is popped when the DUT hands the result over.
// -----------------------------------------------------------------------------
module tb_nn_acc_requant;

    localparam int WAIT_LIMIT = 200;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [15:0] cfg_len;
    logic [5:0]  cfg_shift;
    logic [47:0] cfg_bias;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] sb[$];
    logic [35:0] prods[$];

    nn_acc_requant dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .cfg_bias  (cfg_bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    // Reference requantisation using ideal integer maths.
    function automatic logic [17:0] requant(input longint acc, input int shift, input longint bias);
        longint s;
        s = acc + bias;
        if (shift > 0 && shift < 62) s = s + (longint'(1) <<< (shift - 1));
        s = s >>> shift;
        if (s < 0) return 18'd0;
        if (s > 262143) return 18'h3FFFF;
        return s[17:0];
    endfunction

    // Drives every entry of prods as one job, with gap idle cycles after each
    // product. Returns at the falling edge right after the last accept.
    // cfg_* are scrambled after the first accept so any late sampling shows up.
    task automatic send_job(input int len, input int shift, input longint bias,
                            input int gap, input bit push);
        longint acc = 0;
        int     n;
        cfg_len   = 16'(len);
        cfg_shift = 6'(shift);
        cfg_bias  = bias[47:0];
        for (int i = 0; i < prods.size(); i++) begin
            in_valid = 1'b1;
            in_data  = prods[i];
            n = 0;
            while (!in_ready && n < WAIT_LIMIT) begin
                @(negedge ap_clk);
                n++;
            end
            checks++;
            if (!in_ready) begin
                errors++;
                $display("FAIL in_ready_wait: in_ready=%0b, required 1 within %0d cycles", in_ready, WAIT_LIMIT);
            end
            @(negedge ap_clk);
            acc = acc + longint'(prods[i]);
            if (acc > 64'h0000_FFFF_FFFF_FFFF) acc = 64'h0000_FFFF_FFFF_FFFF;
            if (i == 0) begin
                cfg_len   = 16'd1;
                cfg_shift = 6'd17;
                cfg_bias  = 48'h8000_0000_0000;
            end
            in_valid = 1'b0;
            in_data  = 36'hF_0F0F_0F0F;
            repeat (gap) @(negedge ap_clk);
        end
        if (push) sb.push_back(requant(acc, shift, bias));
    endtask

    // Waits (bounded) for out_valid, captures out_data, then completes the handshake.
    task automatic get_result(output logic [17:0] d, output bit ok);
        int n = 0;
        while (!out_valid && n < WAIT_LIMIT) begin
            @(negedge ap_clk);
            n++;
        end
        ok = out_valid;
        d  = out_data;
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
    endtask

    task automatic expect_result(input string name);
        logic [17:0] d;
        logic [17:0] exp;
        bit          ok;
        get_result(d, ok);
        exp = sb.pop_front();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: out_valid never rose, required result %0d", name, exp);
        end else if (d !== exp) begin
            errors++;
            $display("FAIL %s: out_data=%0d, required %0d", name, d, exp);
        end
    endtask

    task automatic test_reset();
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        cfg_len   = '0;
        cfg_shift = '0;
        cfg_bias  = '0;
        #12;
        checks++;
        if ({out_valid, busy, out_data} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%0b busy=%0b out_data=%0d, required 0 0 0", out_valid, busy, out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%0b, required 1", in_ready);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    task automatic test_basic_latency();
        prods = '{36'd10, 36'd20, 36'd30};
        send_job(3, 0, 0, 0, 1'b1);
        // One FIN cycle separates the last accept from out_valid.
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fin_cycle: out_valid=%0b busy=%0b in_ready=%0b, required 0 1 0", out_valid, busy, in_ready);
        end
        @(negedge ap_clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 18'd60) begin
            errors++;
            $display("FAIL out_latency: out_valid=%0b out_data=%0d, required 1 60", out_valid, out_data);
        end
        expect_result("sum_60");
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_handshake: busy=%0b out_valid=%0b, required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_single_and_round();
        prods = '{36'd5};
        send_job(1, 1, 0, 0, 1'b1);
        expect_result("round_5_shr1");
        prods = '{36'd4};
        send_job(1, 1, 0, 0, 1'b1);
        expect_result("round_4_shr1");
        prods = '{36'd7};
        send_job(0, 0, 0, 0, 1'b1);
        expect_result("len0_as_1");
    endtask

    task automatic test_bias();
        prods = '{36'd100, 36'd50};
        send_job(2, 0, -200, 0, 1'b1);
        expect_result("relu_neg_bias");
        prods = '{36'd100, 36'd50};
        send_job(2, 0, -100, 0, 1'b1);
        expect_result("neg_bias_50");
        prods = '{36'd1000, 36'd2000, 36'd3000};
        send_job(3, 3, 1234, 0, 1'b1);
        expect_result("pos_bias_shr3");
    endtask

    task automatic test_saturation();
        prods = '{36'hF_FFFF_FFFF};
        send_job(1, 0, 0, 0, 1'b1);
        expect_result("clamp_single_max");
        prods.delete();
        for (int i = 0; i < 5000; i++) prods.push_back(36'hF_FFFF_FFFF);
        send_job(5000, 30, 0, 0, 1'b1);
        expect_result("acc_saturate");
    endtask

    task automatic test_backpressure();
        logic [17:0] exp;
        int          n = 0;
        prods = '{36'd7, 36'd8};
        send_job(2, 0, 0, 0, 1'b1);
        while (!out_valid && n < WAIT_LIMIT) begin
            @(negedge ap_clk);
            n++;
        end
        exp      = sb[0];
        in_valid = 1'b1;
        in_data  = 36'd999;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: out_valid=%0b out_data=%0d in_ready=%0b, required 1 %0d 0",
                         c, out_valid, out_data, in_ready, exp);
            end
            @(negedge ap_clk);
        end
        in_valid = 1'b0;
        expect_result("stall_release");
        // Gapped stream; a consumed stall product would also corrupt this job.
        prods = '{36'd1000, 36'd2000, 36'd3000, 36'd4000};
        send_job(4, 2, 5, 2, 1'b1);
        expect_result("gapped_stream");
    endtask

    task automatic test_reset_mid_op();
        prods = '{36'd11, 36'd12};
        send_job(4, 0, 0, 0, 1'b0);
        checks++;
        if (busy !== 1'b1 || out_data === 18'd0) begin
            errors++;
            $display("FAIL pre_abort_state: busy=%0b out_data=%0d, required busy 1 and nonzero data", busy, out_data);
        end
        #2 ap_rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, out_data} !== 20'd0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%0b busy=%0b out_data=%0d, required 0 0 0", out_valid, busy, out_data);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        prods = '{36'd1, 36'd2};
        send_job(2, 0, 0, 0, 1'b1);
        expect_result("post_abort_job");
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_single_and_round();
        test_bias();
        test_saturation();
        test_backpressure();
        test_reset_mid_op();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
